uart_rx_word_packer: RTL

UART_RX_WORD_PACKER -- requirements
Module: uart_rx_word_packer

---
 rtl/uart_rx_word_packer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes little-endian into words and queues them in a 2-entry FIFO.
// Define UART_PACK_TIMEOUT_EN to discard partial words after i_Timeout idle clocks.
module uart_rx_word_packer #(
   parameter int unsigned UART_DATA_WIDTH   = 8,
   parameter int unsigned WORD_BYTES        = 4,
   parameter int unsigned CONFIG_DATA_WIDTH = 32
) (
   input  logic                                    i_Clock,
   input  logic                                    i_Rst_n,
   input  logic                                    i_Rx_DV,
   input  logic [UART_DATA_WIDTH-1:0]              i_Rx_Byte,
   input  logic [CONFIG_DATA_WIDTH-1:0]            i_Timeout,
   input  logic                                    i_Word_Ready,
   output logic                                    o_Word_Valid,
   output logic [UART_DATA_WIDTH*WORD_BYTES-1:0]   o_Word,
   output logic                                    o_Overflow,
   input  logic                                    i_Ovf_Clr,
   output logic                                    o_Timeout
);

   localparam int unsigned WordWidth = UART_DATA_WIDTH * WORD_BYTES;
   localparam int unsigned CntW      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [CntW-1:0] LastByte = CntW'(WORD_BYTES - 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      byte_cnt_q, byte_cnt_d;
   logic [WordWidth-1:0] partial_q, partial_d;
   logic [WordWidth-1:0] word_next;
   logic                 word_done;
   logic                 timeout_hit;

   logic [WordWidth-1:0] fifo_mem_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           fifo_cnt_q, fifo_cnt_d;
   logic                 fifo_valid, fifo_full, do_pop, do_push, drop;
   logic                 ovf_q, ovf_d;

   assign word_done = i_Rx_DV && (byte_cnt_q == LastByte);

`ifdef UART_PACK_TIMEOUT_EN
   logic [CONFIG_DATA_WIDTH-1:0] timer_q, timer_d;
   logic                         timeout_q;

   // A strobe in the expiry cycle wins: the byte is kept and the timer restarts.
   assign timeout_hit = (state_q == S_COLLECT) && !i_Rx_DV && (i_Timeout != '0) &&
                        (timer_q == i_Timeout);

   always_comb begin
      timer_d = '0;
      if ((state_q == S_COLLECT) && !i_Rx_DV && !timeout_hit) begin
         timer_d = timer_q + CONFIG_DATA_WIDTH'(1);
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         timeout_q <= timeout_hit;
      end
   end

   assign o_Timeout = timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^i_Timeout;
   assign timeout_hit    = 1'b0;
   assign o_Timeout      = 1'b0;
`endif

   // State register
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_Rx_DV && !word_done) begin
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (word_done || timeout_hit) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Byte assembly
   always_comb begin
      word_next = partial_q;
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
         if (byte_cnt_q == CntW'(b)) begin
            word_next[b*UART_DATA_WIDTH +: UART_DATA_WIDTH] = i_Rx_Byte;
         end
      end
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      partial_d  = partial_q;
      if (i_Rx_DV) begin
         if (word_done) begin
            byte_cnt_d = '0;
            partial_d  = '0;
         end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
            partial_d  = word_next;
         end
      end else if (timeout_hit) begin
         byte_cnt_d = '0;
         partial_d  = '0;
      end
   end

   // Output FIFO: pop is resolved before push, so a full FIFO can accept a word being read out.
   always_comb begin
      fifo_valid = (fifo_cnt_q != 2'd0);
      fifo_full  = (fifo_cnt_q == 2'd2);
      do_pop     = fifo_valid && i_Word_Ready;
      do_push    = word_done && (!fifo_full || do_pop);
      drop       = word_done && fifo_full && !do_pop;
      fifo_cnt_d = fifo_cnt_q + 2'(do_push) - 2'(do_pop);
      ovf_d      = (ovf_q && !i_Ovf_Clr) || drop;
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         byte_cnt_q    <= '0;
         partial_q     <= '0;
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         fifo_cnt_q    <= 2'd0;
         ovf_q         <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         partial_q  <= partial_d;
         if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= word_next;
         end
         wr_ptr_q   <= wr_ptr_q ^ do_push;
         rd_ptr_q   <= rd_ptr_q ^ do_pop;
         fifo_cnt_q <= fifo_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // Outputs
   always_comb begin
      o_Word_Valid = fifo_valid;
      o_Word       = '0;
      if (fifo_valid) begin
         o_Word = fifo_mem_q[rd_ptr_q];
      end
      o_Overflow = ovf_q;
   end

endmodule
